// File: rtl/spi_write_if.sv
// spi_write_if -- request/serial-bus bundle for the SPI write engine.
//
// Signals:
//   triger   level request; accepted in IDLE when R_W=1
//   R_W      1 = write (handled), 0 = read (ignored by the write engine)
//   Addr     7-bit register address, sent MSB first after the control bit
//   DATA_IN  8-bit write data, sent MSB first after the address
//   SPI_EN   chip enable, high for the whole frame
//   SPI_CLK  serial clock, idles low, device samples on its rising edge
//   SPI_IN   serial data towards the device, 0 when idle
//   busy     high whenever the engine is not idle
//   done     one-cycle completion pulse
//
// Modports:
//   master  requester side (drives the request, observes the serial bus)
//   slave   engine side (spi_write)
interface spi_write_if;
  logic       triger;
  logic       R_W;
  logic [6:0] Addr;
  logic [7:0] DATA_IN;
  logic       SPI_EN;
  logic       SPI_CLK;
  logic       SPI_IN;
  logic       busy;
  logic       done;

  modport master (
    output triger, R_W, Addr, DATA_IN,
    input  SPI_EN, SPI_CLK, SPI_IN, busy, done
  );

  modport slave (
    input  triger, R_W, Addr, DATA_IN,
    output SPI_EN, SPI_CLK, SPI_IN, busy, done
  );
endinterface

// File: rtl/spi_write.sv
// spi_write -- serialises one 16-bit SPI write frame {1, Addr, DATA_IN},
// MSB first. Each bit occupies two FSM_Clk cycles (SPI_CLK low, then high),
// followed by one TAIL cycle with SPI_EN still high and one DONE cycle that
// pulses done. All outputs are registered.
//
// Ports:
//   FSM_Clk  input   FSM clock, rising-edge active
//   Reset_n  input   asynchronous active-low reset
//   bus      slave   request inputs and serial/status outputs (spi_write_if)
module spi_write (
  input  logic        FSM_Clk,
  input  logic        Reset_n,
  spi_write_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;       // {bit index, clock phase}
  logic [15:0] frame_q, frame_d;

  logic en_q, en_d;
  logic sclk_q, sclk_d;
  logic sdi_q, sdi_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  always_ff @(posedge FSM_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      en_q    <= 1'b0;
      sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      en_q    <= en_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are decoded from the *next* state/counter/frame so that the
  // registered pins already show phase k in the cycle right after edge E+k.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    en_d    = 1'b0;
    sclk_d  = 1'b0;
    sdi_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.triger && bus.R_W) begin
          state_d = SHIFT;
          cnt_d   = '0;
          frame_d = {1'b1, bus.Addr, bus.DATA_IN};
        end
      end
      SHIFT: begin
        if (cnt_q == 5'd31) begin
          state_d = TAIL;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      TAIL: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      SHIFT: begin
        en_d   = 1'b1;
        sclk_d = cnt_d[0];
        sdi_d  = frame_d[4'd15 - cnt_d[4:1]];
        busy_d = 1'b1;
      end
      TAIL: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.SPI_EN  = en_q;
  assign bus.SPI_CLK = sclk_q;
  assign bus.SPI_IN  = sdi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_spi_write.sv
// tb_spi_write -- self-checking bench for spi_write. Expected pin values for
// each cycle of a frame are computed from the frame word and the cycle offset
// after the accept edge; bits seen on SPI_CLK rising edges are collected and
// compared against the frame word independently.
module tb_spi_write;

  logic FSM_Clk = 1'b0;
  logic Reset_n = 1'b0;

  spi_write_if bus ();

  spi_write dut (
    .FSM_Clk (FSM_Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 FSM_Clk = ~FSM_Clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {SPI_EN, SPI_CLK, SPI_IN, busy, done} in the cycle after E+t.
  function automatic logic [4:0] model_pins(input logic [15:0] frame,
                                            input int t);
    logic [15:0] sh;
    if (t < 32) begin
      sh = frame >> (15 - t / 2);
      return {1'b1, 1'(t % 2), sh[0], 1'b1, 1'b0};
    end else if (t == 32) begin
      return 5'b10010;
    end else if (t == 33) begin
      return 5'b00011;
    end
    return 5'b00000;
  endfunction

  function automatic logic [4:0] pins();
    return {bus.SPI_EN, bus.SPI_CLK, bus.SPI_IN, bus.busy, bus.done};
  endfunction

  // Bits as the device would see them.
  logic sampled[$];
  always @(posedge bus.SPI_CLK) sampled.push_back(bus.SPI_IN);

  // Protocol checker: data moves only into a low clock phase, clock moves
  // only while enable is (and was) high.
  logic p_in, p_clk, p_en;
  bit   p_valid = 1'b0;
  always @(negedge FSM_Clk) begin
    if (Reset_n && p_valid) begin
      if (bus.SPI_IN !== p_in)   check_eq("proto_in_while_clk", 32'(bus.SPI_CLK), 32'd0);
      if (bus.SPI_CLK !== p_clk) check_eq("proto_clk_while_noen", 32'(bus.SPI_EN & p_en), 32'd1);
    end
    p_in    = bus.SPI_IN;
    p_clk   = bus.SPI_CLK;
    p_en    = bus.SPI_EN;
    p_valid = Reset_n;
  end

  task automatic request(input logic [6:0] a, input logic [7:0] d);
    @(negedge FSM_Clk);
    bus.triger  = 1'b1;
    bus.R_W     = 1'b1;
    bus.Addr    = a;
    bus.DATA_IN = d;
  endtask

  // Follows one frame from its accept edge to the first IDLE cycle.
  // scr_t >= 0: overwrite Addr/DATA_IN at that offset; rnd: randomise
  // triger/R_W while busy; hold: leave triger high for a back-to-back frame.
  task automatic watch_frame(input logic [15:0] frame, input bit hold,
                             input int scr_t, input logic [6:0] na,
                             input logic [7:0] nd, input bit rnd);
    int          dones;
    logic [15:0] sh;
    dones = 0;
    @(posedge FSM_Clk);
    sampled.delete();
    for (int t = 0; t <= 34; t++) begin
      @(negedge FSM_Clk);
      check_eq($sformatf("pins_t%0d", t), 32'(pins()), 32'(model_pins(frame, t)));
      if (bus.done) dones++;
      if (t == 0 && !hold) bus.triger = 1'b0;
      if (t == scr_t) begin
        bus.Addr    = na;
        bus.DATA_IN = nd;
      end
      if (rnd && t >= 1 && t <= 32) begin
        bus.triger = 1'($urandom);
        bus.R_W    = 1'($urandom);
      end
      if (t == 33) begin
        bus.triger = hold;
        bus.R_W    = 1'b1;
      end
    end
    check_eq("bit_count", 32'(sampled.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      sh = frame >> (15 - i);
      if (i < sampled.size()) check_eq($sformatf("bit%0d", i), 32'(sampled[i]), 32'(sh[0]));
    end
    check_eq("done_pulses", 32'(dones), 32'd1);
  endtask

  initial begin
    logic [6:0]  a;
    logic [7:0]  d;
    logic [15:0] f;
    int          dones;

    bus.triger  = 1'b0;
    bus.R_W     = 1'b0;
    bus.Addr    = '0;
    bus.DATA_IN = '0;

    // Reset state
    repeat (3) @(negedge FSM_Clk);
    check_eq("reset_pins", 32'(pins()), 32'd0);
    Reset_n = 1'b1;
    @(negedge FSM_Clk);
    check_eq("idle_pins", 32'(pins()), 32'd0);

    // Basic write 0x2A / 0xC3
    request(7'h2A, 8'hC3);
    watch_frame({1'b1, 7'h2A, 8'hC3}, 1'b0, -1, '0, '0, 1'b0);

    // Read request ignored
    @(negedge FSM_Clk);
    bus.triger = 1'b1;
    bus.R_W    = 1'b0;
    bus.Addr   = 7'h55;
    for (int i = 0; i < 40; i++) begin
      @(negedge FSM_Clk);
      check_eq("read_ignored", 32'(pins()), 32'd0);
    end
    bus.triger = 1'b0;

    // Inputs changed mid-frame do not affect the frame in flight
    request(7'h2A, 8'hC3);
    watch_frame({1'b1, 7'h2A, 8'hC3}, 1'b0, 5, 7'h7F, 8'h00, 1'b0);

    // Mid-frame reset at E+10
    request(7'h33, 8'h96);
    f = {1'b1, 7'h33, 8'h96};
    @(posedge FSM_Clk);
    for (int t = 0; t < 10; t++) begin
      @(negedge FSM_Clk);
      check_eq($sformatf("prereset_t%0d", t), 32'(pins()), 32'(model_pins(f, t)));
      if (t == 0) bus.triger = 1'b0;
    end
    @(posedge FSM_Clk);
    #2 Reset_n = 1'b0;
    #1 check_eq("async_reset_pins", 32'(pins()), 32'd0);
    dones = 0;
    repeat (3) begin
      @(negedge FSM_Clk);
      if (bus.done) dones++;
    end
    Reset_n = 1'b1;
    repeat (3) begin
      @(negedge FSM_Clk);
      if (bus.done) dones++;
    end
    check_eq("no_done_after_abort", 32'(dones), 32'd0);
    request(7'h0F, 8'h5A);
    watch_frame({1'b1, 7'h0F, 8'h5A}, 1'b0, -1, '0, '0, 1'b0);

    // Back-to-back with triger held
    request(7'h01, 8'hFF);
    watch_frame({1'b1, 7'h01, 8'hFF}, 1'b1, -1, '0, '0, 1'b0);
    watch_frame({1'b1, 7'h01, 8'hFF}, 1'b0, -1, '0, '0, 1'b0);
    @(negedge FSM_Clk);
    check_eq("idle_after_b2b", 32'(pins()), 32'd0);

    // Randomised frames with mid-frame input noise
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge FSM_Clk);
      a = 7'($urandom);
      d = 8'($urandom);
      request(a, d);
      watch_frame({1'b1, a, d}, 1'b0, int'($urandom_range(1, 31)),
                  7'($urandom), 8'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
